xc_malu_pmul_seq: RTL and testbench

//  Self-sequencing, parametrised packed multiplier for the MALU: carryless (clmul) or integer multiply on XLEN-bit packed lanes.

---
 rtl/xc_malu_pmul_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_xc_malu_pmul_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_pmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : xc_malu_pmul_seq
// Purpose  : Self-sequencing packed multiplier (carryless or unsigned integer)
//            over 2/4/8/16/XLEN-bit lanes. STEP multiplier bits are consumed
//            per cycle. Latency is W/STEP cycles regardless of operand values.
// Revision : 1.0  initial release
// ============================================================================
module xc_malu_pmul_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic              g_clk,
  input  logic              g_rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  input  logic              req_carryless,
  input  logic              req_pw_16,
  input  logic              req_pw_8,
  input  logic              req_pw_4,
  input  logic              req_pw_2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2*XLEN-1:0] rsp_result,
  output logic              busy
);

  // Counter wide enough to hold XLEN itself (used for the end-of-op compare).
  localparam int c_CW   = $clog2(XLEN) + 1;
  // Number of supported lane-width options: 2, 4, 8, 16, XLEN.
  localparam int c_NWID = 5;
  localparam logic [c_CW-1:0] c_STEP_INC = c_CW'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // The accumulator uses a "product layout": lane i owns the contiguous 2W-bit
  // slot [2W*i +: 2W]. Every partial sum of a lane is bounded by that lane's
  // final product (< 2^(2W)), so a single full-width add can never carry out
  // of a slot, which keeps lanes independent without explicit carry breaks.
  state_t              r_state;
  logic [c_CW-1:0]     r_count;
  logic [2*XLEN-1:0]   r_acc;
  logic [2*XLEN-1:0]   r_a_sp;      // rs1 lanes spread into the slot layout
  logic [XLEN-1:0]     r_rs2;
  logic                r_carryless;
  logic [2:0]          r_wsel;      // 0:2 1:4 2:8 3:16 4:XLEN
  logic [c_CW-1:0]     r_w;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [2*XLEN-1:0]   r_rsp_result;
  logic                r_busy;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [2:0]                          w_wsel_in;
  logic [c_CW-1:0]                     w_w_in;
  logic [c_NWID-1:0][2*XLEN-1:0]       w_a_sp;
  logic [c_NWID-1:0][2*XLEN-1:0]       w_unp;
  logic [2*XLEN-1:0]                   w_a_sp_sel;
  logic [2*XLEN-1:0]                   w_unp_sel;
  logic [STEP-1:0][2*XLEN-1:0]         w_pp;
  logic [2*XLEN-1:0]                   w_acc_nxt;
  logic [c_CW-1:0]                     w_cnt_nxt;

  // Lane width decode with pw_2 > pw_4 > pw_8 > pw_16 priority.
  always_comb begin
    w_wsel_in = 3'd4;
    w_w_in    = c_CW'(XLEN);
    if (req_pw_2) begin
      w_wsel_in = 3'd0;
      w_w_in    = c_CW'(2);
    end else if (req_pw_4) begin
      w_wsel_in = 3'd1;
      w_w_in    = c_CW'(4);
    end else if (req_pw_8) begin
      w_wsel_in = 3'd2;
      w_w_in    = c_CW'(8);
    end else if (req_pw_16) begin
      w_wsel_in = 3'd3;
      w_w_in    = c_CW'(16);
    end
  end

  // Per-width spread of rs1 into slots and unpack of the next accumulator.
  for (genvar g = 0; g < c_NWID; g++) begin : g_wid
    localparam int LW = (g == c_NWID - 1) ? XLEN : (2 << g);
    for (genvar i = 0; i < XLEN / LW; i++) begin : g_lane
      assign w_a_sp[g][2*LW*i +: 2*LW]  = {{LW{1'b0}}, req_rs1[i*LW +: LW]};
      assign w_unp[g][i*LW +: LW]       = w_acc_nxt[2*LW*i +: LW];
      assign w_unp[g][XLEN+i*LW +: LW]  = w_acc_nxt[2*LW*i+LW +: LW];
    end
  end

  // Select the spread operand (at accept) and the packed result (at finish).
  always_comb begin
    w_a_sp_sel = w_a_sp[c_NWID-1];
    w_unp_sel  = w_unp[c_NWID-1];
    case (w_wsel_in)
      3'd0:    w_a_sp_sel = w_a_sp[0];
      3'd1:    w_a_sp_sel = w_a_sp[1];
      3'd2:    w_a_sp_sel = w_a_sp[2];
      3'd3:    w_a_sp_sel = w_a_sp[3];
      default: w_a_sp_sel = w_a_sp[c_NWID-1];
    endcase
    case (r_wsel)
      3'd0:    w_unp_sel = w_unp[0];
      3'd1:    w_unp_sel = w_unp[1];
      3'd2:    w_unp_sel = w_unp[2];
      3'd3:    w_unp_sel = w_unp[3];
      default: w_unp_sel = w_unp[c_NWID-1];
    endcase
  end

  // One partial product per multiplier bit handled this cycle. A bit index
  // beyond the lane width shifts the lane's rs2 to zero, so that partial
  // product vanishes (matters only when STEP exceeds the lane width).
  for (genvar k = 0; k < STEP; k++) begin : g_step
    logic [c_CW-1:0]               w_bit;
    logic [c_NWID-1:0][2*XLEN-1:0] w_msk;
    logic [2*XLEN-1:0]             w_msk_sel;

    assign w_bit = r_count + c_CW'(k);

    for (genvar g = 0; g < c_NWID; g++) begin : g_mwid
      localparam int LW = (g == c_NWID - 1) ? XLEN : (2 << g);
      for (genvar i = 0; i < XLEN / LW; i++) begin : g_mlane
        assign w_msk[g][2*LW*i +: 2*LW] =
          {(2*LW){|((r_rs2[i*LW +: LW] >> w_bit) & {{(LW-1){1'b0}}, 1'b1})}};
      end
    end

    // Pick the lane mask for the latched width.
    always_comb begin
      w_msk_sel = w_msk[c_NWID-1];
      case (r_wsel)
        3'd0:    w_msk_sel = w_msk[0];
        3'd1:    w_msk_sel = w_msk[1];
        3'd2:    w_msk_sel = w_msk[2];
        3'd3:    w_msk_sel = w_msk[3];
        default: w_msk_sel = w_msk[c_NWID-1];
      endcase
    end

    assign w_pp[k] = (r_a_sp << w_bit) & w_msk_sel;
  end

  // Accumulate this cycle's partial products (XOR for GF(2), add otherwise).
  always_comb begin
    w_acc_nxt = r_acc;
    for (int k = 0; k < STEP; k++) begin
      if (r_carryless) begin
        w_acc_nxt = w_acc_nxt ^ w_pp[k];
      end else begin
        w_acc_nxt = w_acc_nxt + w_pp[k];
      end
    end
  end

  assign w_cnt_nxt = r_count + c_STEP_INC;

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs; reset beats flush beats handshakes.
  // --------------------------------------------------------------------------
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_acc        <= '0;
      r_a_sp       <= '0;
      r_rs2        <= '0;
      r_carryless  <= 1'b0;
      r_wsel       <= 3'd4;
      r_w          <= c_CW'(XLEN);
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_busy       <= 1'b0;
    end else if (flush) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_acc        <= '0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state     <= ST_BUSY;
            r_count     <= '0;
            r_acc       <= '0;
            r_a_sp      <= w_a_sp_sel;
            r_rs2       <= req_rs2;
            r_carryless <= req_carryless;
            r_wsel      <= w_wsel_in;
            r_w         <= w_w_in;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_count <= w_cnt_nxt;
          if (w_cnt_nxt >= r_w) begin
            r_state      <= ST_DONE;
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= w_unp_sel;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state      <= ST_IDLE;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b1;
          r_rsp_valid  <= 1'b0;
          r_rsp_result <= '0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_pmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_xc_malu_pmul_seq
// Purpose  : Scoreboard bench for xc_malu_pmul_seq (XLEN=32, STEP=1).
// Revision : 1.0  initial release
// ============================================================================
module tb_xc_malu_pmul_seq;

  localparam int XLEN = 32;
  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        cl = 1'b0;
  logic [3:0]  pw = '0;          // {pw_16, pw_8, pw_4, pw_2}
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [63:0] rsp_result;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          rr_mode = 0;      // 0: rsp_ready=1, 1: random, 2: manual

  typedef struct {
    logic [63:0] res;
    int unsigned rise;
  } exp_t;
  exp_t q[$];

  xc_malu_pmul_seq #(.XLEN(XLEN), .STEP(STEP)) dut (
    .g_clk         (clk),
    .g_rst         (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rs1       (rs1),
    .req_rs2       (rs2),
    .req_carryless (cl),
    .req_pw_16     (pw[3]),
    .req_pw_8      (pw[2]),
    .req_pw_4      (pw[1]),
    .req_pw_2      (pw[0]),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .busy          (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lane_w(input logic [3:0] p);
    if (p[0]) return 2;
    if (p[1]) return 4;
    if (p[2]) return 8;
    if (p[3]) return 16;
    return 32;
  endfunction

  // Lane-by-lane reference product from plain arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input int w);
    logic [63:0]     r;
    longint unsigned x, y, p;
    r = '0;
    for (int i = 0; i < 32 / w; i++) begin
      x = 0;
      y = 0;
      for (int j = 0; j < w; j++) begin
        x[j] = a[i*w+j];
        y[j] = b[i*w+j];
      end
      if (c) begin
        p = 0;
        for (int j = 0; j < w; j++) if (y[j]) p = p ^ (x << j);
      end else begin
        p = x * y;
      end
      for (int j = 0; j < w; j++) begin
        r[i*w+j]    = p[j];
        r[32+i*w+j] = p[w+j];
      end
    end
    return r;
  endfunction

  // rsp_ready driver, settled well before the sampling point.
  always @(posedge clk) begin
    #2;
    if (rr_mode == 0) rsp_ready = 1'b1;
    else if (rr_mode == 1) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on each response handshake.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    #1;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp_valid", 64'(rsp_valid), 64'd0);
      end else begin
        if (!prev_valid) chk("latency_rise_cycle", 64'(cyc), 64'(q[0].rise));
        chk("rsp_result", rsp_result, q[0].res);
        chk("req_ready_in_done", 64'(req_ready), 64'd0);
        if (rsp_ready && !flush && !rst) void'(q.pop_front());
      end
    end else begin
      chk("result_zero_when_invalid", rsp_result, 64'd0);
    end
    prev_valid = rsp_valid;
  end

  // Issue one request; n returns the cycles waited for req_ready.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [3:0] p, input bit push, input logic [63:0] exp,
                      output int n);
    exp_t e;
    @(negedge clk);
    rs1 = a; rs2 = b; cl = c; pw = p; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1");
    end else if (push) begin
      e.res  = exp;
      e.rise = cyc + 1 + lane_w(p) / STEP;
      q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; cl = 1'($urandom_range(0, 1)); pw = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(q.size()), 64'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready), 64'd1);
    chk({tag, "_rsp_valid"},  64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_result"}, rsp_result, 64'd0);
    chk({tag, "_busy"},       64'(busy), 64'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] a, b;
    logic [3:0]  p;
    logic        c;
    bit          seen;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;

    // Directed cases with known products.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0000, 1, 64'hFFFFFFFE_00000001, n);
    wait_idle();
    send(32'h00000003, 32'h00000003, 1'b1, 4'b0000, 1, 64'h00000000_00000005, n);
    wait_idle();
    send(32'h02030405, 32'h02020202, 1'b0, 4'b0100, 1, 64'h00000000_0406080A, n);
    wait_idle();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0100, 1, 64'hFEFEFEFE_01010101, n);
    wait_idle();
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'b1000, 1, 64'h55555555_55555555, n);
    wait_idle();
    // pw_2 wins over pw_4: 2-bit lanes of 3*3 = 9 -> low 01, high 10.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'b0011, 1, 64'hAAAAAAAA_55555555, n);
    wait_idle();

    // Randomised traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      rr_mode = $urandom_range(0, 1);
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      p = (t % 3 == 0) ? 4'($urandom) : (4'd1 << $urandom_range(0, 3)) & {4{t % 5 != 1}};
      send(a, b, c, p, 1, ref_mul(a, b, c, lane_w(p)), n);
    end
    rr_mode = 0;
    wait_idle();

    // Hold the response for 5 cycles, then release; next request goes straight in.
    rr_mode = 2;
    rsp_ready = 1'b0;
    a = $urandom; b = $urandom;
    send(a, b, 1'b0, 4'b1000, 1, ref_mul(a, b, 1'b0, 16), n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_valid_seen", 64'(rsp_valid), 64'd1);
    repeat (5) @(negedge clk);
    rsp_ready = 1'b1;
    a = $urandom; b = $urandom;
    send(a, b, 1'b1, 4'b0010, 1, ref_mul(a, b, 1'b1, 4), n);
    chk("accept_right_after_release", 64'(n), 64'd0);
    rr_mode = 0;
    wait_idle();

    // Flush on the third BUSY cycle: no response may appear.
    send(32'hDEADBEEF, 32'h12345678, 1'b0, 4'b0000, 0, 64'd0, n);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_reset_outs("flush_busy");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("flush_no_response", 64'(seen), 64'd0);

    // Flush in IDLE blocks acceptance for that cycle.
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_idle_not_accepted", 64'(busy), 64'd0);
    chk("flush_idle_req_ready", 64'(req_ready), 64'd1);

    // Reset in the middle of BUSY.
    send(32'hCAFEF00D, 32'h0F0F0F0F, 1'b1, 4'b0000, 0, 64'd0, n);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_busy");
    rst = 1'b0;

    // Reset and flush together behave as reset.
    send(32'h13572468, 32'h24681357, 1'b0, 4'b0100, 0, 64'd0, n);
    repeat (3) @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk_reset_outs("rst_flush");
    rst = 1'b0; flush = 1'b0;

    // Recovery after reset.
    a = $urandom; b = $urandom;
    send(a, b, 1'b0, 4'b0000, 1, ref_mul(a, b, 1'b0, 32), n);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
